// File: rtl/bmc_encoder_if.sv
// bmc_encoder_if: block handshake and BMC line bundle for the BMC transmitter.
// Revision: 1.0
`default_nettype none

interface bmc_encoder_if #(
  parameter int BLOCK_W = 28
);
  logic [BLOCK_W-1:0] i_block;
  logic               valid_in;
  logic               ready_out;
  logic               o_bit;
  logic               valid_out;

  modport master (
    output i_block, valid_in,
    input  ready_out, o_bit, valid_out
  );

  modport slave (
    input  i_block, valid_in,
    output ready_out, o_bit, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/bmc_encoder.sv
// bmc_encoder: Biphase Mark Code transmitter, MSB-first, one-deep hold for gapless blocks.
// Revision: 1.0
`default_nettype none

module bmc_encoder #(
  parameter int HALF_CYCLES = 1,
  parameter int BLOCK_W     = 28
) (
  input  wire logic  clk,
  input  wire logic  rst,   // asynchronous, active-low
  bmc_encoder_if.slave bus
);

  localparam int c_idx_w = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int c_hc_w  = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BLOCK_W - 1);
  localparam logic [c_hc_w-1:0]  c_hc_last  = c_hc_w'(HALF_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state,   w_state_nxt;
  logic [BLOCK_W-1:0]   r_shifter, w_shifter_nxt;
  logic [BLOCK_W-1:0]   r_hold,    w_hold_nxt;
  logic                 r_hold_v,  w_hold_v_nxt;
  logic [c_idx_w-1:0]   r_bit_idx, w_bit_idx_nxt;
  logic                 r_half,    w_half_nxt;
  logic [c_hc_w-1:0]    r_hcnt,    w_hcnt_nxt;
  logic                 r_level,   w_level_nxt;
  logic                 r_strobe,  w_strobe_nxt;

  logic w_accept;
  logic w_hc_end;
  logic w_blk_end;

  assign bus.ready_out = ~r_hold_v;
  assign bus.o_bit     = r_level;
  assign bus.valid_out = r_strobe;

  assign w_accept  = bus.valid_in & ~r_hold_v;
  assign w_hc_end  = (r_hcnt == c_hc_last);
  assign w_blk_end = (r_state == S_BUSY) & w_hc_end & r_half & (r_bit_idx == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shifter <= '0;
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_bit_idx <= '0;
      r_half    <= 1'b0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shifter <= w_shifter_nxt;
      r_hold    <= w_hold_nxt;
      r_hold_v  <= w_hold_v_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_half    <= w_half_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_level   <= w_level_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  // Outputs are registered one cycle ahead: the level for the next half-cell
  // is computed here so it lands on o_bit together with its strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_shifter_nxt = r_shifter;
    w_hold_nxt    = r_hold;
    w_hold_v_nxt  = r_hold_v;
    w_bit_idx_nxt = r_bit_idx;
    w_half_nxt    = r_half;
    w_hcnt_nxt    = r_hcnt;
    w_level_nxt   = r_level;
    w_strobe_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = S_BUSY;
          w_shifter_nxt = bus.i_block;
          w_bit_idx_nxt = c_last_idx;
          w_half_nxt    = 1'b0;
          w_hcnt_nxt    = '0;
          w_level_nxt   = ~r_level;
          w_strobe_nxt  = 1'b1;
        end
      end

      S_BUSY: begin
        if (!w_hc_end) begin
          w_hcnt_nxt = r_hcnt + c_hc_w'(1);
        end else begin
          w_hcnt_nxt = '0;
          if (!r_half) begin
            w_half_nxt   = 1'b1;
            w_level_nxt  = r_level ^ r_shifter[r_bit_idx];
            w_strobe_nxt = 1'b1;
          end else if (r_bit_idx != '0) begin
            w_half_nxt    = 1'b0;
            w_bit_idx_nxt = r_bit_idx - c_idx_w'(1);
            w_level_nxt   = ~r_level;
            w_strobe_nxt  = 1'b1;
          end else if (r_hold_v) begin
            w_shifter_nxt = r_hold;
            w_hold_v_nxt  = 1'b0;
            w_half_nxt    = 1'b0;
            w_bit_idx_nxt = c_last_idx;
            w_level_nxt   = ~r_level;
            w_strobe_nxt  = 1'b1;
          end else if (w_accept) begin
            w_shifter_nxt = bus.i_block;
            w_half_nxt    = 1'b0;
            w_bit_idx_nxt = c_last_idx;
            w_level_nxt   = ~r_level;
            w_strobe_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_half_nxt  = 1'b0;
          end
        end

        // A block arriving on the final cycle goes straight to the shifter above.
        if (w_accept && !w_blk_end) begin
          w_hold_nxt   = bus.i_block;
          w_hold_v_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bmc_encoder.sv
// tb_bmc_encoder: directed bench for bmc_encoder with a BMC-rule model and an in-bench decoder.
// Revision: 1.0
`default_nettype none

module tb_bmc_encoder;

  localparam int BW    = 28;
  localparam int NCELL = 2 * BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bmc_encoder_if #(.BLOCK_W(BW)) bif1 ();
  bmc_encoder_if #(.BLOCK_W(BW)) bif3 ();

  bmc_encoder #(.HALF_CYCLES(1), .BLOCK_W(BW)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));
  bmc_encoder #(.HALF_CYCLES(3), .BLOCK_W(BW)) u_dut3 (.clk(clk), .rst(rst), .bus(bif3));

  // Model: queue of {first_of_block, level} per half-cell, built from BMC rules.
  logic [1:0]    cq    [2][$];
  logic [BW-1:0] acc_q [2][$];
  logic          m_lvl [2];
  logic          m_cur [2];
  logic          m_stb [2];
  logic          m_act [2];
  int            m_cnt [2];
  int            m_pend[2];
  int            m_accn[2];
  int            dn    [2];
  logic          dprev [2];
  logic [BW-1:0] dblk  [2];
  logic [111:0]  cap   [2];
  int            capn  [2];
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic int hc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  task automatic model_reset(input int i);
    cq[i].delete();
    acc_q[i].delete();
    m_lvl[i] = 1'b0; m_cur[i] = 1'b0; m_stb[i] = 1'b0; m_act[i] = 1'b0;
    m_cnt[i] = 0; m_pend[i] = 0; dn[i] = 0; dprev[i] = 1'b0; dblk[i] = '0;
  endtask

  task automatic push_block(input int i, input logic [BW-1:0] b);
    for (int k = BW - 1; k >= 0; k--) begin
      m_lvl[i] = ~m_lvl[i];
      cq[i].push_back({(k == BW - 1) ? 1'b1 : 1'b0, m_lvl[i]});
      if (b[k]) m_lvl[i] = ~m_lvl[i];
      cq[i].push_back({1'b0, m_lvl[i]});
    end
    acc_q[i].push_back(b);
    m_pend[i]++;
    m_accn[i]++;
  endtask

  task automatic sample(input int i, output logic ob, output logic vo, output logic ro);
    if (i == 0) begin ob = bif1.o_bit; vo = bif1.valid_out; ro = bif1.ready_out; end
    else        begin ob = bif3.o_bit; vo = bif3.valid_out; ro = bif3.ready_out; end
  endtask

  task automatic drive(input int i, input logic v, input logic [BW-1:0] b);
    if (i == 0) begin bif1.valid_in = v; bif1.i_block = b; end
    else        begin bif3.valid_in = v; bif3.i_block = b; end
  endtask

  // Advance the model over the coming clock edge using the inputs it will sample.
  task automatic step(input int i);
    logic          vin;
    logic [BW-1:0] blk;
    logic [1:0]    c;
    if (!rst) begin
      model_reset(i);
      return;
    end
    vin = (i == 0) ? bif1.valid_in : bif3.valid_in;
    blk = (i == 0) ? bif1.i_block  : bif3.i_block;
    if (vin && m_pend[i] == 0) push_block(i, blk);
    if (!m_act[i] || m_cnt[i] == 1) begin
      if (cq[i].size() > 0) begin
        c = cq[i].pop_front();
        m_cur[i] = c[0]; m_stb[i] = 1'b1; m_cnt[i] = hc_of(i); m_act[i] = 1'b1;
        if (c[1]) m_pend[i]--;
      end else begin
        m_act[i] = 1'b0; m_stb[i] = 1'b0;
      end
    end else begin
      m_cnt[i]--; m_stb[i] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    logic ob, vo, ro;
    sample(i, ob, vo, ro);
    check($sformatf("valid_out[%0d]", i), 128'(vo), 128'(m_stb[i]));
    check($sformatf("o_bit[%0d]", i),     128'(ob), 128'(m_cur[i]));
    check($sformatf("ready_out[%0d]", i), 128'(ro), 128'(m_pend[i] == 0));
    if (vo) begin
      cap[i] = {cap[i][110:0], ob};
      capn[i]++;
      // Independent decode: pair strobes into dibits, bit = levels differ.
      if (dn[i] % 2 == 0) dprev[i] = ob;
      else dblk[i] = {dblk[i][BW-2:0], dprev[i] ^ ob};
      dn[i]++;
      if (dn[i] == NCELL) begin
        dn[i] = 0;
        if (acc_q[i].size() > 0) check($sformatf("decode[%0d]", i), 128'(dblk[i]), 128'(acc_q[i].pop_front()));
        else fail_now($sformatf("decode_unexpected[%0d]", i));
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic send(input int i, input logic [BW-1:0] b);
    logic acc = 1'b0;
    int   n = 0;
    drive(i, 1'b1, b);
    while (!acc && n < 2000) begin
      acc = (m_pend[i] == 0);
      tick();
      n++;
    end
    drive(i, 1'b0, b);
    if (!acc) fail_now("send_accept");
  endtask

  task automatic wait_idle(input int i, output int n);
    n = 0;
    while ((m_act[i] || cq[i].size() > 0) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) fail_now("wait_idle");
  endtask

  task automatic clr_cap(input int i);
    cap[i] = '0;
    capn[i] = 0;
  endtask

  initial begin
    int n;
    int a0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      m_accn[i] = 0;
      clr_cap(i);
      drive(i, 1'b0, '0);
    end

    // Reset state
    repeat (3) tick();
    check("reset_o_bit", 128'(bif1.o_bit), 128'(0));
    check("reset_ready", 128'(bif1.ready_out), 128'(1));
    rst = 1'b1;
    tick();

    // Single block, HALF_CYCLES=1
    clr_cap(0);
    send(0, 28'h8000001);
    wait_idle(0, n);
    check("t1_strobes", 128'(capn[0]), 128'(56));
    check("t1_seq", 128'(cap[0][55:0]), 128'({2'b10, {13{4'b1100}}, 2'b10}));
    check("t1_level", 128'(bif1.o_bit), 128'(0));

    // Back-to-back via hold
    clr_cap(0);
    send(0, 28'hFFFFFFF);
    send(0, 28'h0000000);
    check("t2_ready_low", 128'(bif1.ready_out), 128'(0));
    wait_idle(0, n);
    check("t2_strobes", 128'(capn[0]), 128'(112));
    check("t2_seq", 128'(cap[0]), 128'({{28{2'b10}}, {14{4'b1100}}}));

    // HALF_CYCLES=3 block timing
    clr_cap(1);
    send(1, 28'h0000001);
    wait_idle(1, n);
    check("t3_len", 128'(n), 128'(168));
    check("t3_strobes", 128'(capn[1]), 128'(56));
    check("t3_seq", 128'(cap[1][55:0]), 128'({{13{4'b1100}}, 2'b11, 2'b01}));
    check("t3_level", 128'(bif3.o_bit), 128'(1));
    check("t3_idle_strobe", 128'(bif3.valid_out), 128'(0));

    // Random loopback on both rates
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) send(i, BW'($urandom));
      wait_idle(i, n);
    end

    // valid_in held high while i_block changes
    a0 = m_accn[0];
    for (int k = 0; k < 200; k++) begin
      drive(0, 1'b1, 28'h1234000 + BW'(k));
      tick();
    end
    drive(0, 1'b0, '0);
    check("t5_accepts", 128'(m_accn[0] - a0), 128'(5));
    wait_idle(0, n);

    // Reset mid-block with hold occupied
    clr_cap(0);
    send(0, 28'h1111111);
    send(0, 28'h2222222);
    n = 0;
    while (capn[0] < 20 && n < 200) begin
      tick();
      n++;
    end
    if (capn[0] < 20) fail_now("t6_reach_strobe20");
    check("t6_pre_hold", 128'(bif1.ready_out), 128'(0));
    rst = 1'b0;
    #1;
    check("t6_rst_o_bit", 128'(bif1.o_bit), 128'(0));
    check("t6_rst_valid", 128'(bif1.valid_out), 128'(0));
    check("t6_rst_ready", 128'(bif1.ready_out), 128'(1));
    repeat (2) tick();
    rst = 1'b1;
    clr_cap(0);
    send(0, 28'hA5A5A5A);
    repeat (3) tick();
    check("t6_restart_seq", 128'(cap[0][3:0]), 128'(4'b1011));
    wait_idle(0, n);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
